// File: rtl/dbus_demux.sv
// dbus_demux: routes one core load/store at a time to one of four targets selected by req_addr[31:28].
// Optional macro DBUS_TIMEOUT_EN builds a watchdog that aborts a stuck ISSUE/WAIT phase.
module dbus_demux #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [31:0]  req_addr,
    input  logic [31:0]  req_wdata,
    input  logic         req_we,
    input  logic [3:0]   req_be,
    output logic         rsp_valid,
    output logic [31:0]  rsp_rdata,
    output logic         rsp_err,
    output logic [3:0]   t_valid,
    output logic [31:0]  t_addr,
    output logic [31:0]  t_wdata,
    output logic         t_we,
    output logic [3:0]   t_be,
    input  logic [3:0]   t_ready,
    input  logic [3:0]   t_rsp_valid,
    input  logic [127:0] t_rdata
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  sel;
    logic [1:0]  sel_nxt;
    logic [31:0] rdata_cap;
    logic [31:0] rdata_cap_nxt;
    logic        err_cap;
    logic        err_cap_nxt;
    logic        accept;
    logic        mapped;
    logic        timeout_hit;

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        logic [3:0] v;
        v      = 4'b0000;
        v[idx] = 1'b1;
        return v;
    endfunction

    assign accept = (state == IDLE) && req_valid;
    assign mapped = (req_addr[31:30] == 2'b00);

`ifdef DBUS_TIMEOUT_EN
    logic [7:0] tmo_cnt;

    // Watchdog counter: cleared on acceptance, counts every ISSUE/WAIT cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= 8'd0;
        end else if (accept) begin
            tmo_cnt <= 8'd0;
        end else if ((state == ISSUE) || (state == WAIT)) begin
            tmo_cnt <= tmo_cnt + 8'd1;
        end
    end

    // The edge that would bring the count to TIMEOUT_CYCLES is the abort edge
    assign timeout_hit = ((state == ISSUE) || (state == WAIT)) &&
                         (tmo_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // Next-state logic and response capture
    always_comb begin
        state_nxt     = state;
        sel_nxt       = sel;
        rdata_cap_nxt = rdata_cap;
        err_cap_nxt   = err_cap;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    sel_nxt       = req_addr[29:28];
                    rdata_cap_nxt = 32'h0000_0000;
                    if (mapped) begin
                        state_nxt   = ISSUE;
                        err_cap_nxt = 1'b0;
                    end else begin
                        state_nxt   = RESP;
                        err_cap_nxt = 1'b1;
                    end
                end else begin
                    state_nxt = IDLE;
                end
            end
            ISSUE: begin
                if (timeout_hit) begin
                    state_nxt     = RESP;
                    rdata_cap_nxt = 32'h0000_0000;
                    err_cap_nxt   = 1'b1;
                end else if (t_ready[sel]) begin
                    state_nxt = WAIT;
                end else begin
                    state_nxt = ISSUE;
                end
            end
            WAIT: begin
                if (timeout_hit) begin
                    state_nxt     = RESP;
                    rdata_cap_nxt = 32'h0000_0000;
                    err_cap_nxt   = 1'b1;
                end else if (t_rsp_valid[sel]) begin
                    state_nxt     = RESP;
                    rdata_cap_nxt = t_we ? 32'h0000_0000 : t_rdata[{sel, 5'd0} +: 32];
                    err_cap_nxt   = 1'b0;
                end else begin
                    state_nxt = WAIT;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, latched request fields and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sel       <= 2'd0;
            rdata_cap <= 32'h0000_0000;
            err_cap   <= 1'b0;
            req_ready <= 1'b1;
            t_valid   <= 4'b0000;
            t_addr    <= 32'h0000_0000;
            t_wdata   <= 32'h0000_0000;
            t_we      <= 1'b0;
            t_be      <= 4'b0000;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0000_0000;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            sel       <= sel_nxt;
            rdata_cap <= rdata_cap_nxt;
            err_cap   <= err_cap_nxt;
            req_ready <= (state_nxt == IDLE);
            t_valid   <= (state_nxt == ISSUE) ? onehot(sel_nxt) : 4'b0000;
            if (accept) begin
                t_addr  <= req_addr;
                t_wdata <= req_wdata;
                t_we    <= req_we;
                t_be    <= req_be;
            end
            // Response leaves RESP as a one-cycle registered pulse
            rsp_valid <= (state == RESP);
            rsp_rdata <= (state == RESP) ? rdata_cap : 32'h0000_0000;
            rsp_err   <= (state == RESP) && err_cap;
        end
    end
endmodule

// File: tb/tb_dbus_demux.sv
// Self-checking bench for dbus_demux: vector table driven through a target model, responses
// checked through a scoreboard queue; timeout behaviour depends on DBUS_TIMEOUT_EN.
module tb_dbus_demux;
    logic         clk;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [31:0]  req_addr;
    logic [31:0]  req_wdata;
    logic         req_we;
    logic [3:0]   req_be;
    logic         rsp_valid;
    logic [31:0]  rsp_rdata;
    logic         rsp_err;
    logic [3:0]   t_valid;
    logic [31:0]  t_addr;
    logic [31:0]  t_wdata;
    logic         t_we;
    logic [3:0]   t_be;
    logic [3:0]   t_ready;
    logic [3:0]   t_rsp_valid;
    logic [127:0] t_rdata;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic [3:0]  be;
        logic [31:0] tgt_rdata;
        logic [3:0]  ready_dly;
        logic        stray;
        logic [3:0]  exp_tvalid;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    vec_t       vecs [9];
    exp_t       sb [$];
    exp_t       mon_e;
    logic [3:0] exp_tvalid;
    int         n_vec;
    int         n_fail;

    dbus_demux #(.TIMEOUT_CYCLES(15)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_we(req_we), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .t_valid(t_valid), .t_addr(t_addr), .t_wdata(t_wdata), .t_we(t_we), .t_be(t_be),
        .t_ready(t_ready), .t_rsp_valid(t_rsp_valid), .t_rdata(t_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard pops on every response and the target strobe is checked each cycle
    always @(negedge clk) begin
        if (!rst) begin
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: got rsp_valid=1 rdata=0x%08h, expected none at %0t",
                             rsp_rdata, $time);
                end else begin
                    mon_e = sb.pop_front();
                    check("rsp_rdata", rsp_rdata, mon_e.rdata);
                    check("rsp_err", 32'(rsp_err), 32'(mon_e.err));
                end
            end
            check("t_valid_sel", 32'((t_valid == 4'b0000) || (t_valid == exp_tvalid)), 32'd1);
        end
    end

    task automatic run_vec(input vec_t v);
        exp_t e;
        check("idle_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_we    = v.we;
        req_be    = v.be;
        e.rdata   = v.exp_rdata;
        e.err     = v.exp_err;
        sb.push_back(e);
        exp_tvalid = v.exp_tvalid;
        step();
        req_valid = 1'b0;
        req_addr  = ~v.addr;
        req_wdata = ~v.wdata;
        req_we    = ~v.we;
        req_be    = ~v.be;
        check("busy_ready", 32'(req_ready), 32'd0);
        check("t_valid_issue", 32'(t_valid), 32'(v.exp_tvalid));
        if (v.exp_tvalid == 4'b0000) begin
            step();
            check("err_latency", 32'(rsp_valid), 32'd1);
        end else begin
            check("t_addr", t_addr, v.addr);
            check("t_wdata", t_wdata, v.wdata);
            check("t_we", 32'(t_we), 32'(v.we));
            check("t_be", 32'(t_be), 32'(v.be));
            for (int i = 0; i < int'(v.ready_dly); i++) begin
                if (v.stray) begin
                    t_rsp_valid = 4'b1111;
                    t_rdata     = {4{32'hBAD0_0BAD}};
                end
                step();
                check("t_valid_hold", 32'(t_valid), 32'(v.exp_tvalid));
            end
            t_rsp_valid = 4'b0000;
            t_ready     = v.exp_tvalid;
            step();
            t_ready = 4'b0000;
            check("t_valid_wait", 32'(t_valid), 32'd0);
            if (v.stray) begin
                t_rsp_valid = ~v.exp_tvalid;
                t_rdata     = {4{32'h5555_AAAA}};
                step();
                t_rsp_valid = 4'b0000;
                check("stray_wait", 32'(req_ready), 32'd0);
            end
            for (int n = 0; n < 4; n++) begin
                t_rdata[32*n +: 32] = v.exp_tvalid[n] ? v.tgt_rdata : (32'hF00D_0000 | 32'(n));
            end
            t_rsp_valid = v.exp_tvalid;
            step();
            t_rsp_valid = 4'b0000;
            t_rdata     = 128'h0;
            check("rsp_early", 32'(rsp_valid), 32'd0);
            step();
            check("rsp_latency", 32'(rsp_valid), 32'd1);
        end
        step();
        check("rsp_pulse", 32'(rsp_valid), 32'd0);
        check("t_addr_hold", t_addr, v.addr);
        check("t_we_hold", 32'(t_we), 32'(v.we));
    endtask

    initial begin
        int   cnt;
        int   tv;
        int   guard;
        exp_t e;
        n_vec       = 0;
        n_fail      = 0;
        exp_tvalid  = 4'b0000;
        rst         = 1'b1;
        req_valid   = 1'b0;
        req_addr    = 32'h0;
        req_wdata   = 32'h0;
        req_we      = 1'b0;
        req_be      = 4'b0000;
        t_ready     = 4'b0000;
        t_rsp_valid = 4'b0000;
        t_rdata     = 128'h0;

        //         addr          wdata         we    be       tgt_rdata     dly   stray exp_tv   exp_rdata     err
        vecs[0] = '{32'h1000_0010, 32'h0,        1'b0, 4'b1111, 32'hDEAD_BEEF, 4'd0, 1'b0, 4'b0010, 32'hDEAD_BEEF, 1'b0};
        vecs[1] = '{32'h3000_0004, 32'h1234_5678, 1'b1, 4'b0011, 32'hA5A5_A5A5, 4'd0, 1'b0, 4'b1000, 32'h0,         1'b0};
        vecs[2] = '{32'h8000_0000, 32'h0,        1'b0, 4'b1111, 32'h0,         4'd0, 1'b0, 4'b0000, 32'h0,         1'b1};
        vecs[3] = '{32'h2000_0100, 32'h0,        1'b0, 4'b1111, 32'hCAFE_F00D, 4'd5, 1'b1, 4'b0100, 32'hCAFE_F00D, 1'b0};
        vecs[4] = '{32'h0000_0FFC, 32'h0,        1'b0, 4'b0001, 32'h0BAD_F00D, 4'd1, 1'b0, 4'b0001, 32'h0BAD_F00D, 1'b0};
        vecs[5] = '{32'h1FFF_FFFC, 32'hFFFF_0000, 1'b1, 4'b1100, 32'h7777_7777, 4'd2, 1'b1, 4'b0010, 32'h0,         1'b0};
        vecs[6] = '{32'h4000_0000, 32'h0,        1'b0, 4'b1111, 32'h0,         4'd0, 1'b0, 4'b0000, 32'h0,         1'b1};
        vecs[7] = '{32'hF000_0000, 32'h0,        1'b1, 4'b1111, 32'h0,         4'd0, 1'b0, 4'b0000, 32'h0,         1'b1};
        vecs[8] = '{32'h3FFF_FFF0, 32'h0,        1'b0, 4'b1111, 32'h89AB_CDEF, 4'd0, 1'b0, 4'b1000, 32'h89AB_CDEF, 1'b0};

        #12;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_t_valid", 32'(t_valid), 32'd0);
        check("rst_t_addr", t_addr, 32'd0);
        check("rst_t_wdata", t_wdata, 32'd0);
        check("rst_t_be_we", {27'd0, t_be, t_we}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();

        for (int k = 0; k < 9; k++) begin
            run_vec(vecs[k]);
        end

`ifdef DBUS_TIMEOUT_EN
        // Target 0 never acknowledges: abort after 15 ISSUE cycles
        e.rdata = 32'h0;
        e.err   = 1'b1;
        sb.push_back(e);
        exp_tvalid = 4'b0001;
        req_valid  = 1'b1;
        req_addr   = 32'h0000_0040;
        req_we     = 1'b0;
        step();
        req_valid = 1'b0;
        cnt       = 0;
        guard     = 0;
        while (!rsp_valid && guard < 200) begin
            if (t_valid == 4'b0001) cnt++;
            step();
            guard++;
        end
        check("timeout_issue_cycles", 32'(cnt), 32'd15);
        check("timeout_rsp", 32'(rsp_valid), 32'd1);
        step();
        check("timeout_pulse", 32'(rsp_valid), 32'd0);
`else
        // Without the watchdog a silent target stalls ISSUE until reset
        exp_tvalid = 4'b0001;
        req_valid  = 1'b1;
        req_addr   = 32'h0000_0040;
        req_we     = 1'b0;
        step();
        req_valid = 1'b0;
        cnt       = 0;
        tv        = 0;
        for (int i = 0; i < 100; i++) begin
            if (rsp_valid) cnt++;
            if (t_valid == 4'b0001) tv++;
            step();
        end
        check("no_timeout_rsp", 32'(cnt), 32'd0);
        check("no_timeout_hold", 32'(tv), 32'd100);
        #2 rst = 1'b1;
        #1;
        check("rst_issue_t_valid", 32'(t_valid), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_issue_ready", 32'(req_ready), 32'd1);
        step();
`endif

        // Reset during WAIT abandons the load with no response
        exp_tvalid = 4'b1000;
        req_valid  = 1'b1;
        req_addr   = 32'h3000_0008;
        req_we     = 1'b0;
        step();
        req_valid = 1'b0;
        t_ready   = 4'b1000;
        step();
        t_ready = 4'b0000;
        check("pre_rst_wait", 32'(t_valid), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("rst_wait_t_valid", 32'(t_valid), 32'd0);
        check("rst_wait_idle", 32'(req_ready), 32'd1);
        check("rst_wait_rsp", 32'(rsp_valid), 32'd0);
        check("rst_wait_t_addr", t_addr, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_release_ready", 32'(req_ready), 32'd1);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (rsp_valid) cnt++;
            step();
        end
        check("rst_no_rsp", 32'(cnt), 32'd0);

        run_vec(vecs[0]);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "bench watchdog expired");
    end
endmodule
